tx_serial_sequencer: RTL

- Sequences the TX parallel-to-serial shift register: accepts bytes over a valid/ready handshake, drives its load and shift strobes, times bit periods and inserts stuff bits.
- Sits between the TX packet FSM (byte source) and the shift register / line encoder.
- Stuffing rule: after STUFF_LIMIT consecutive 1s on the serial line, one 0 period is inserted.
- A byte underrun mid-packet is an error; the line cannot pause.

---
 rtl/tx_seq_pkg.sv | 15 +
 rtl/tx_bit_timer.sv | 44 ++++
 rtl/tx_serial_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/tx_seq_pkg.sv
// Shared types and default constants for the TX serial sequencer.
package tx_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STUFF = 2'd2,
    DONE  = 2'd3
  } tx_seq_state_t;

  localparam int DEF_CLKS_PER_BIT = 8;
  localparam int DEF_DATA_BITS    = 8;
  localparam int DEF_STUFF_LIMIT  = 6;

endpackage

// File: rtl/tx_bit_timer.sv
// Serial bit-period counter; flags the first cycle and the last cycle of each period.
module tx_bit_timer
  import tx_seq_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic run,
  input  logic active_next,
  output logic bit_strobe,
  output logic period_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             bit_strobe_reg;

  assign period_end = run && (cnt_reg == CNT_MAX);
  assign bit_strobe = bit_strobe_reg;

  // Counter parks at 0 while idle so the first period after a load starts cleanly.
  always_comb begin
    cnt_next = '0;
    if (!clr && run && !period_end) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_reg        <= '0;
      bit_strobe_reg <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      bit_strobe_reg <= active_next && (cnt_next == '0);
    end
  end

endmodule

// File: rtl/tx_serial_sequencer.sv
// Drives load/shift strobes of the TX shift register, times bit periods and inserts stuff bits.
module tx_serial_sequencer
  import tx_seq_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int STUFF_LIMIT  = DEF_STUFF_LIMIT
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 src_valid,
  input  logic [DATA_BITS-1:0] src_data,
  input  logic                 src_last,
  output logic                 src_ready,
  input  logic                 abort,
  input  logic                 sr_serial,
  output logic                 sr_load,
  output logic                 sr_shift,
  output logic [DATA_BITS-1:0] sr_par,
  output logic                 stuff_active,
  output logic                 bit_strobe,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx_error
);

  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int ONES_W = $clog2(STUFF_LIMIT + 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic [ONES_W-1:0] STUFF_MAX = ONES_W'(STUFF_LIMIT);

  tx_seq_state_t     state_reg, state_next;
  logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [ONES_W-1:0] ones_cnt_reg, ones_cnt_next;
  logic [ONES_W-1:0] ones_inc;
  logic              last_flag_reg, last_flag_next;
  logic              pending_reg, pending_next;
  logic              tx_done_reg, tx_error_reg, stuff_active_reg, tx_busy_reg;
  logic              err_next, err_load, boundary, stuff_need, accept;
  logic              period_end, timer_run, busy_next;

  assign timer_run = (state_reg == DATA) || (state_reg == STUFF);
  assign busy_next = (state_next == DATA) || (state_next == STUFF);

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk        (clk),
    .n_rst      (n_rst),
    .clr        (accept || abort),
    .run        (timer_run),
    .active_next(busy_next),
    .bit_strobe (bit_strobe),
    .period_end (period_end)
  );

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    ones_cnt_next  = ones_cnt_reg;
    last_flag_next = last_flag_reg;
    pending_next   = pending_reg;
    ones_inc       = ones_cnt_reg + 1'b1;
    stuff_need     = 1'b0;
    boundary       = 1'b0;
    err_next       = 1'b0;
    err_load       = 1'b0;
    sr_shift       = 1'b0;

    case (state_reg)
      DATA: begin
        if (period_end) begin
          stuff_need    = sr_serial && (ones_inc == STUFF_MAX);
          ones_cnt_next = (sr_serial && !stuff_need) ? ones_inc : '0;
          if (bit_cnt_reg < LAST_BIT) begin
            sr_shift     = 1'b1;
            bit_cnt_next = bit_cnt_reg + 1'b1;
            if (stuff_need) state_next = STUFF;
          end else if (stuff_need) begin
            state_next   = STUFF;
            pending_next = 1'b1;
          end else begin
            boundary = 1'b1;
          end
        end
      end
      STUFF: begin
        ones_cnt_next = '0;
        if (period_end) begin
          if (pending_reg) boundary = 1'b1;
          else             state_next = DATA;
        end
      end
      DONE: begin
        ones_cnt_next = '0;
        state_next    = IDLE;
      end
      default: ;
    endcase

    // Underrun: the line cannot pause, so force idle-high and report.
    if (boundary) begin
      pending_next = 1'b0;
      if (last_flag_reg) begin
        state_next = DONE;
      end else if (!src_valid) begin
        err_next      = 1'b1;
        err_load      = 1'b1;
        ones_cnt_next = '0;
        state_next    = IDLE;
      end
    end

    src_ready = src_valid && !abort &&
                ((state_reg == IDLE) || (boundary && !last_flag_reg));
    accept    = src_ready;

    if (accept) begin
      last_flag_next = src_last;
      bit_cnt_next   = '0;
      pending_next   = 1'b0;
      state_next     = DATA;
    end

    if (abort) begin
      state_next     = IDLE;
      bit_cnt_next   = '0;
      ones_cnt_next  = '0;
      last_flag_next = 1'b0;
      pending_next   = 1'b0;
      err_next       = 1'b0;
      sr_shift       = 1'b0;
    end

    sr_load = accept || err_load || abort;
    sr_par  = accept ? src_data : '1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg        <= IDLE;
      bit_cnt_reg      <= '0;
      ones_cnt_reg     <= '0;
      last_flag_reg    <= 1'b0;
      pending_reg      <= 1'b0;
      tx_done_reg      <= 1'b0;
      tx_error_reg     <= 1'b0;
      stuff_active_reg <= 1'b0;
      tx_busy_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      bit_cnt_reg      <= bit_cnt_next;
      ones_cnt_reg     <= ones_cnt_next;
      last_flag_reg    <= last_flag_next;
      pending_reg      <= pending_next;
      tx_done_reg      <= (state_next == DONE);
      tx_error_reg     <= err_next;
      stuff_active_reg <= (state_next == STUFF);
      tx_busy_reg      <= busy_next;
    end
  end

  assign tx_done      = tx_done_reg;
  assign tx_error     = tx_error_reg;
  assign stuff_active = stuff_active_reg;
  assign tx_busy      = tx_busy_reg;

endmodule
